// File: rtl/rvfi_check_pkg.sv
// Shared types and helpers for the RVFI instruction-memory learn/check block.
package rvfi_check_pkg;

    localparam int unsigned HW_BYTES = 2;

    typedef logic [15:0] halfword_t;

    function automatic logic is_rvc(input logic [31:0] insn);
        return insn[1:0] != 2'b11;
    endfunction

    // Modular distance from the window base; callers truncate to their XLEN.
    function automatic logic [63:0] win_offset(input logic [63:0] addr,
                                               input logic [63:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/rvfi_imem_window_slot.sv
// One watched halfword: a valid bit plus the learned value, written once after reset.
module rvfi_imem_window_slot (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        learn_i,
    input  logic [15:0] data_i,
    output logic        valid_o,
    output logic [15:0] data_o
);

    logic        valid_q;
    logic [15:0] data_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (learn_i && !valid_q) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/rvfi_imem_learn_check.sv
// Self-learning instruction-memory consistency checker on the RVFI retire bus.
// Define RVFI_IMEM_ASSERT_EN to add an immediate assertion on every halfword compare.
module rvfi_imem_learn_check
    import rvfi_check_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NRET      = 1,
    parameter int unsigned NWATCH    = 4,
    parameter int unsigned SKIP_TRAP = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [XLEN-1:0]                        win_base,
    input  logic [NRET-1:0]                        rvfi_valid,
    input  logic [NRET*32-1:0]                     rvfi_insn,
    input  logic [NRET-1:0]                        rvfi_trap,
    input  logic [NRET*XLEN-1:0]                   rvfi_pc_rdata,
    output logic                                   err,
    output logic [((NRET > 1) ? $clog2(NRET) : 1)-1:0] err_chan,
    output logic [XLEN-1:0]                        err_addr,
    output logic [15:0]                            err_expected,
    output logic [15:0]                            err_actual,
    output logic [$clog2(NWATCH):0]                learned_cnt
);

    localparam int unsigned CW   = (NRET > 1) ? $clog2(NRET) : 1;
    localparam int unsigned SW   = (NWATCH > 1) ? $clog2(NWATCH) : 1;
    localparam int unsigned CNTW = $clog2(NWATCH) + 1;
    localparam int unsigned NEV  = 2 * NRET;

    logic [NWATCH-1:0] slot_valid;
    halfword_t         slot_data  [NWATCH];
    logic [NWATCH-1:0] learn;
    halfword_t         learn_data [NWATCH];

    for (genvar s = 0; s < NWATCH; s++) begin : g_slot
        rvfi_imem_window_slot u_slot (
            .clk_i   (clk),
            .reset_i (reset),
            .learn_i (learn[s]),
            .data_i  (learn_data[s]),
            .valid_o (slot_valid[s]),
            .data_o  (slot_data[s])
        );
    end

    logic [XLEN-1:0]   base_eff;
    logic [NWATCH-1:0] vld_w;
    halfword_t         dat_w [NWATCH];
    logic [31:0]       insn_c;
    halfword_t         hw;
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   off;
    logic              en;
    logic [SW-1:0]     idx;
    logic [NEV-1:0]    ev_cmp;
    logic [NEV-1:0]    ev_mis;
    logic              found;
    logic [CW-1:0]     f_chan;
    logic [XLEN-1:0]   f_addr;
    halfword_t         f_exp;
    halfword_t         f_act;

    assign base_eff = win_base & ~XLEN'(1);

    // Walk channels in order, lo before hi, against a working copy of the slots so that a
    // value learned earlier this cycle is already visible to later halfwords.
    always_comb begin
        vld_w      = slot_valid;
        dat_w      = slot_data;
        learn      = '0;
        learn_data = slot_data;
        insn_c     = '0;
        hw         = '0;
        addr       = '0;
        off        = '0;
        en         = 1'b0;
        idx        = '0;
        ev_cmp     = '0;
        ev_mis     = '0;
        found      = 1'b0;
        f_chan     = '0;
        f_addr     = '0;
        f_exp      = '0;
        f_act      = '0;
        for (int c = 0; c < NRET; c++) begin
            insn_c = rvfi_insn[c*32 +: 32];
            for (int h = 0; h < 2; h++) begin
                hw   = (h == 0) ? insn_c[15:0] : insn_c[31:16];
                addr = rvfi_pc_rdata[c*XLEN +: XLEN] + ((h == 0) ? '0 : XLEN'(HW_BYTES));
                off  = XLEN'(win_offset(64'(addr), 64'(base_eff)));
                en   = rvfi_valid[c] && !((SKIP_TRAP != 0) && rvfi_trap[c])
                       && ((h == 0) || !is_rvc(insn_c))
                       && !off[0] && (off < XLEN'(2 * NWATCH));
                idx  = off[SW:1];
                if (en) begin
                    if (!vld_w[idx]) begin
                        vld_w[idx]      = 1'b1;
                        dat_w[idx]      = hw;
                        learn[idx]      = 1'b1;
                        learn_data[idx] = hw;
                    end else begin
                        ev_cmp[c*2+h] = 1'b1;
                        if (dat_w[idx] != hw) begin
                            ev_mis[c*2+h] = 1'b1;
                            if (!found) begin
                                found  = 1'b1;
                                f_chan = CW'(c);
                                f_addr = addr;
                                f_exp  = dat_w[idx];
                                f_act  = hw;
                            end
                        end
                    end
                end
            end
        end
    end

    logic [CNTW-1:0] cnt_q, cnt_d;
    int unsigned     cnt_sum;

    always_comb begin
        cnt_sum = int'(cnt_q) + $countones(learn);
        cnt_d   = (cnt_sum > NWATCH) ? CNTW'(NWATCH) : CNTW'(cnt_sum);
    end

    logic            err_q;
    logic [CW-1:0]   err_chan_q;
    logic [XLEN-1:0] err_addr_q;
    halfword_t       err_exp_q;
    halfword_t       err_act_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q      <= 1'b0;
            err_chan_q <= '0;
            err_addr_q <= '0;
            err_exp_q  <= '0;
            err_act_q  <= '0;
            cnt_q      <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (found && !err_q) begin
                err_q      <= 1'b1;
                err_chan_q <= f_chan;
                err_addr_q <= f_addr;
                err_exp_q  <= f_exp;
                err_act_q  <= f_act;
            end
`ifdef RVFI_IMEM_ASSERT_EN
            for (int e = 0; e < NEV; e++) begin
                if (ev_cmp[e]) begin
                    assert (!ev_mis[e]);
                end
            end
`endif
        end
    end

    assign err          = err_q;
    assign err_chan     = err_chan_q;
    assign err_addr     = err_addr_q;
    assign err_expected = err_exp_q;
    assign err_actual   = err_act_q;
    assign learned_cnt  = cnt_q;

endmodule
